// File: rtl/matrix_input_parser_if.sv
// matrix_input_parser_if
//   Write bus from the matrix input parser toward the multi-matrix storage.
//   The parser drives it through the master modport, and the storage listens
//   through the slave modport.
//   Signals:
//     wr_en    - one-cycle element write strobe
//     wr_idx   - row-major element index
//     wr_data  - element value
//     dim_row  - parsed row count
//     dim_col  - parsed column count
//     commit   - one-cycle pulse; storage latches the dimensions on it
interface matrix_input_parser_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  wr_en;
  logic [4:0]            wr_idx;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [2:0]            dim_row;
  logic [2:0]            dim_col;
  logic                  commit;

  modport master (
    output wr_en,
    output wr_idx,
    output wr_data,
    output dim_row,
    output dim_col,
    output commit
  );

  modport slave (
    input wr_en,
    input wr_idx,
    input wr_data,
    input dim_row,
    input dim_col,
    input commit
  );
endinterface

// File: rtl/matrix_input_parser.sv
// matrix_input_parser
//   Parses an ASCII byte stream "rows cols e0 e1 ..." from the UART receiver.
//   Each element is range-checked and emitted as a row-major write. When the
//   matrix is complete, the parser pulses commit toward the storage. Every
//   session ends with a one-cycle done pulse that carries an err_code:
//     0 = ok, 1 = illegal character, 2 = dimension out of range,
//     3 = element value > VAL_MAX.
//   Ports:
//     clk, rst_n     - clock and asynchronous active-low reset
//     start_req      - pulse that arms the parser for one matrix
//     busy           - session in progress
//     rx_valid       - one-cycle strobe qualifying rx_data
//     rx_data        - received ASCII byte
//     done           - end-of-session pulse
//     err_code       - result code, valid with done
//     wr_bus         - element write / dimension / commit bus (master side)
//   Build option:
//     MATRIX_PARSER_ZERO_FILL_EN - when defined, a CR/LF that arrives before
//     all elements are present pads the remaining elements with zeros and
//     commits. When undefined, that CR/LF is an illegal-character error.
module matrix_input_parser #(
  parameter int MAX_SIZE   = 5,
  parameter int DATA_WIDTH = 8,
  parameter int VAL_MAX    = 9
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start_req,
  output logic                         busy,
  input  logic                         rx_valid,
  input  logic [7:0]                   rx_data,
  output logic                         done,
  output logic [1:0]                   err_code,
  matrix_input_parser_if.master        wr_bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_ROW,
    S_GET_COL,
    S_GET_ELEM,
    S_FILL,
    S_COMMIT,
    S_ERR
  } state_t;

  localparam logic [1:0] ERR_CHAR = 2'd1;
  localparam logic [1:0] ERR_DIM  = 2'd2;
  localparam logic [1:0] ERR_VAL  = 2'd3;

  state_t                state_q, state_d;
  logic [9:0]            acc_q, acc_d;
  logic                  have_digit_q, have_digit_d;
  logic                  ovf_q, ovf_d;
  logic [4:0]            idx_q, idx_d;
  logic [4:0]            total_q, total_d;
  logic [2:0]            dim_row_q, dim_row_d;
  logic [2:0]            dim_col_q, dim_col_d;
  logic                  wr_en_q, wr_en_d;
  logic [4:0]            wr_idx_q, wr_idx_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  commit_q, commit_d;
  logic                  done_q, done_d;
  logic [1:0]            err_code_q, err_code_d;
  logic                  busy_q, busy_d;

  logic                  is_digit;
  logic                  is_space;
  logic                  is_eol;
  logic [3:0]            digit;
  logic [9:0]            field_limit;
  logic [13:0]           acc_ext;
  logic                  tok_ok_dim;
  logic                  tok_ok_val;
  logic [4:0]            idx_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      acc_q        <= '0;
      have_digit_q <= 1'b0;
      ovf_q        <= 1'b0;
      idx_q        <= '0;
      total_q      <= '0;
      dim_row_q    <= 3'd1;
      dim_col_q    <= 3'd1;
      wr_en_q      <= 1'b0;
      wr_idx_q     <= '0;
      wr_data_q    <= '0;
      commit_q     <= 1'b0;
      done_q       <= 1'b0;
      err_code_q   <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      have_digit_q <= have_digit_d;
      ovf_q        <= ovf_d;
      idx_q        <= idx_d;
      total_q      <= total_d;
      dim_row_q    <= dim_row_d;
      dim_col_q    <= dim_col_d;
      wr_en_q      <= wr_en_d;
      wr_idx_q     <= wr_idx_d;
      wr_data_q    <= wr_data_d;
      commit_q     <= commit_d;
      done_q       <= done_d;
      err_code_q   <= err_code_d;
      busy_q       <= busy_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    have_digit_d = have_digit_q;
    ovf_d        = ovf_q;
    idx_d        = idx_q;
    total_d      = total_q;
    dim_row_d    = dim_row_q;
    dim_col_d    = dim_col_q;
    wr_en_d      = 1'b0;
    wr_idx_d     = wr_idx_q;
    wr_data_d    = wr_data_q;
    commit_d     = 1'b0;
    done_d       = 1'b0;
    err_code_d   = err_code_q;
    busy_d       = busy_q;

    is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    is_space = (rx_data == 8'h20);
    is_eol   = (rx_data == 8'h0D) || (rx_data == 8'h0A);
    digit    = rx_data[3:0];

    // The overflow flag tracks the limit of the field being parsed. It also
    // covers the 10-bit accumulator range, because both limits are below 1023.
    field_limit = (state_q == S_GET_ELEM) ? 10'(VAL_MAX) : 10'(MAX_SIZE);
    acc_ext     = (14'(acc_q) * 14'd10) + 14'(digit);
    tok_ok_dim  = !ovf_q && (acc_q >= 10'd1) && (acc_q <= 10'(MAX_SIZE));
    tok_ok_val  = !ovf_q && (acc_q <= 10'(VAL_MAX));
    idx_next    = idx_q + 5'd1;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        // busy_q is still high in the done cycle, so a start in that cycle
        // is ignored.
        if (start_req && !busy_q) begin
          busy_d       = 1'b1;
          acc_d        = '0;
          have_digit_d = 1'b0;
          ovf_d        = 1'b0;
          idx_d        = '0;
          err_code_d   = '0;
          state_d      = S_GET_ROW;
        end
      end

      S_GET_ROW, S_GET_COL: begin
        if (rx_valid) begin
          if (is_digit) begin
            have_digit_d = 1'b1;
            acc_d        = acc_ext[9:0];
            if (acc_ext > 14'(field_limit)) ovf_d = 1'b1;
          end else if (is_space || is_eol) begin
            // Separators with no pending digits are blank padding.
            if (have_digit_q) begin
              acc_d        = '0;
              have_digit_d = 1'b0;
              ovf_d        = 1'b0;
              if (!tok_ok_dim) begin
                err_code_d = ERR_DIM;
                state_d    = S_ERR;
              end else if (state_q == S_GET_ROW) begin
                dim_row_d = acc_q[2:0];
                state_d   = S_GET_COL;
              end else begin
                dim_col_d = acc_q[2:0];
                total_d   = {2'b00, dim_row_q} * {2'b00, acc_q[2:0]};
                state_d   = S_GET_ELEM;
              end
            end
          end else begin
            err_code_d = ERR_CHAR;
            state_d    = S_ERR;
          end
        end
      end

      S_GET_ELEM: begin
        if (rx_valid) begin
          if (is_digit) begin
            have_digit_d = 1'b1;
            acc_d        = acc_ext[9:0];
            if (acc_ext > 14'(field_limit)) ovf_d = 1'b1;
          end else if (is_space || is_eol) begin
            if (have_digit_q) begin
              acc_d        = '0;
              have_digit_d = 1'b0;
              ovf_d        = 1'b0;
              if (!tok_ok_val) begin
                err_code_d = ERR_VAL;
                state_d    = S_ERR;
              end else begin
                wr_en_d   = 1'b1;
                wr_idx_d  = idx_q;
                wr_data_d = DATA_WIDTH'(acc_q);
                idx_d     = idx_next;
                if (idx_next == total_q) state_d = S_COMMIT;
              end
            end
            // An end of line that arrives while elements are still missing
            // either pads the rest of the matrix or aborts the session.
            if (is_eol && (state_d == S_GET_ELEM)) begin
`ifdef MATRIX_PARSER_ZERO_FILL_EN
              state_d = S_FILL;
`else
              err_code_d = ERR_CHAR;
              state_d    = S_ERR;
`endif
            end
          end else begin
            err_code_d = ERR_CHAR;
            state_d    = S_ERR;
          end
        end
      end

      S_FILL: begin
        // Incoming bytes are dropped while the padding writes go out.
        if (idx_q >= total_q) begin
          state_d = S_COMMIT;
        end else begin
          wr_en_d   = 1'b1;
          wr_idx_d  = idx_q;
          wr_data_d = '0;
          idx_d     = idx_next;
          if (idx_next == total_q) state_d = S_COMMIT;
        end
      end

      S_COMMIT: begin
        commit_d   = 1'b1;
        done_d     = 1'b1;
        err_code_d = '0;
        state_d    = S_IDLE;
      end

      S_ERR: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign err_code       = err_code_q;
  assign wr_bus.wr_en   = wr_en_q;
  assign wr_bus.wr_idx  = wr_idx_q;
  assign wr_bus.wr_data = wr_data_q;
  assign wr_bus.dim_row = dim_row_q;
  assign wr_bus.dim_col = dim_col_q;
  assign wr_bus.commit  = commit_q;

endmodule

// File: tb/tb_matrix_input_parser.sv
// tb_matrix_input_parser
//   Directed bench for matrix_input_parser. It feeds ASCII sessions, logs
//   every write, commit and done seen on the outputs, and compares the logs
//   against hand-computed expectations. The bench follows the
//   MATRIX_PARSER_ZERO_FILL_EN setting of the build.
module tb_matrix_input_parser;

  localparam int DATA_WIDTH = 8;

  logic       clk;
  logic       rst_n;
  logic       start_req;
  logic       busy;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       done;
  logic [1:0] err_code;

  matrix_input_parser_if #(.DATA_WIDTH(DATA_WIDTH)) busInst ();

  matrix_input_parser #(
    .MAX_SIZE  (5),
    .DATA_WIDTH(DATA_WIDTH),
    .VAL_MAX   (9)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_req(start_req),
    .busy     (busy),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .done     (done),
    .err_code (err_code),
    .wr_bus   (busInst.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int testCount = 0;
  int failCount = 0;

  int cycleCount = 0;
  int logIdx[$];
  int logData[$];
  int logCycle[$];
  int commitCount;
  int doneCount;
  int doneErr;
  int doneCycle;
  int busyAtDone;
  int busyAfterDone;

  // The monitor samples outputs on the falling edge, away from the active edge.
  always @(negedge clk) begin
    cycleCount++;
    if (busInst.wr_en) begin
      logIdx.push_back(int'(busInst.wr_idx));
      logData.push_back(int'(busInst.wr_data));
      logCycle.push_back(cycleCount);
    end
    if (busInst.commit) commitCount++;
    if (done) begin
      doneCount++;
      doneErr    = int'(err_code);
      doneCycle  = cycleCount;
      busyAtDone = int'(busy);
    end
    if (doneCount > 0 && cycleCount == doneCycle + 1) busyAfterDone = int'(busy);
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic clearLog();
    logIdx.delete();
    logData.delete();
    logCycle.delete();
    commitCount   = 0;
    doneCount     = 0;
    doneErr       = -1;
    doneCycle     = -10;
    busyAtDone    = -1;
    busyAfterDone = -1;
  endtask

  task automatic sendString(input string s);
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = s[i];
    end
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic applyStimulus(input string s);
    clearLog();
    @(negedge clk);
    start_req = 1'b1;
    @(negedge clk);
    start_req = 1'b0;
    sendString(s);
  endtask

  task automatic waitDone(input string tag);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (doneCount > 0) break;
    end
    if (doneCount == 0) checkOutput({tag, "_done_timeout"}, 0, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic checkSession(input string tag, input int expWrites, input int expErr,
                              input int expCommit);
    checkOutput({tag, "_wr_count"}, logIdx.size(), expWrites);
    checkOutput({tag, "_done_count"}, doneCount, 1);
    checkOutput({tag, "_err_code"}, doneErr, expErr);
    checkOutput({tag, "_commit_count"}, commitCount, expCommit);
    checkOutput({tag, "_busy_after_done"}, busyAfterDone, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    start_req = 1'b0;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    clearLog();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Reset values
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_wr_en", int'(busInst.wr_en), 0);
    checkOutput("rst_commit", int'(busInst.commit), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_wr_idx", int'(busInst.wr_idx), 0);
    checkOutput("rst_wr_data", int'(busInst.wr_data), 0);
    checkOutput("rst_err_code", int'(err_code), 0);
    checkOutput("rst_dim_row", int'(busInst.dim_row), 1);
    checkOutput("rst_dim_col", int'(busInst.dim_col), 1);

    // A complete 2x3 matrix, sent as back-to-back bytes
    applyStimulus("2 3 1 2 3 4 5 6 ");
    waitDone("m2x3");
    checkSession("m2x3", 6, 0, 1);
    for (int i = 0; i < 6 && i < logIdx.size(); i++) begin
      checkOutput($sformatf("m2x3_idx%0d", i), logIdx[i], i);
      checkOutput($sformatf("m2x3_data%0d", i), logData[i], i + 1);
    end
    if (logCycle.size() > 0)
      checkOutput("m2x3_commit_latency", doneCycle - logCycle[logCycle.size()-1], 1);
    checkOutput("m2x3_busy_at_done", busyAtDone, 1);
    checkOutput("m2x3_dim_row", int'(busInst.dim_row), 2);
    checkOutput("m2x3_dim_col", int'(busInst.dim_col), 3);

    // Dimensions out of range
    applyStimulus("6 2 ");
    waitDone("dim6");
    checkSession("dim6", 0, 2, 0);
    applyStimulus("0 ");
    waitDone("dim0");
    checkSession("dim0", 0, 2, 0);

    // Element value above VAL_MAX after one good write
    applyStimulus("1 2 4 12 ");
    waitDone("val12");
    checkSession("val12", 1, 3, 0);
    if (logIdx.size() > 0) begin
      checkOutput("val12_idx0", logIdx[0], 0);
      checkOutput("val12_data0", logData[0], 4);
    end

    // Illegal character after one good write
    applyStimulus("2 2 1 x");
    waitDone("illegal");
    checkSession("illegal", 1, 1, 0);

    // Early end of line
    applyStimulus("2 2 7\n");
    waitDone("eol");
`ifdef MATRIX_PARSER_ZERO_FILL_EN
    checkSession("eol", 4, 0, 1);
    for (int i = 0; i < 4 && i < logIdx.size(); i++) begin
      checkOutput($sformatf("eol_idx%0d", i), logIdx[i], i);
      checkOutput($sformatf("eol_data%0d", i), logData[i], (i == 0) ? 7 : 0);
    end
    if (logCycle.size() == 4) begin
      checkOutput("eol_fill_gap1", logCycle[2] - logCycle[1], 1);
      checkOutput("eol_fill_gap2", logCycle[3] - logCycle[2], 1);
      checkOutput("eol_commit_latency", doneCycle - logCycle[3], 1);
    end
`else
    checkSession("eol", 1, 1, 0);
    if (logIdx.size() > 0) checkOutput("eol_data0", logData[0], 7);
`endif

    // start_req together with a byte in idle: that byte is dropped
    clearLog();
    @(negedge clk);
    start_req = 1'b1;
    rx_valid  = 1'b1;
    rx_data   = "x";
    @(negedge clk);
    start_req = 1'b0;
    rx_valid  = 1'b0;
    sendString("1 1 3 ");
    waitDone("coincident");
    checkSession("coincident", 1, 0, 1);
    if (logData.size() > 0) checkOutput("coincident_data0", logData[0], 3);

    // Asynchronous reset in the middle of a session
    applyStimulus("3 3 1 ");
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy", int'(busy), 0);
    checkOutput("midrst_wr_en", int'(busInst.wr_en), 0);
    checkOutput("midrst_dim_row", int'(busInst.dim_row), 1);
    checkOutput("midrst_dim_col", int'(busInst.dim_col), 1);
    checkOutput("midrst_wr_data", int'(busInst.wr_data), 0);
    repeat (2) @(negedge clk);
    checkOutput("midrst_no_done", doneCount, 0);
    checkOutput("midrst_no_commit", commitCount, 0);
    rst_n = 1'b1;

    applyStimulus("1 1 5 ");
    waitDone("after_rst");
    checkSession("after_rst", 1, 0, 1);
    if (logIdx.size() > 0) begin
      checkOutput("after_rst_idx0", logIdx[0], 0);
      checkOutput("after_rst_data0", logData[0], 5);
    end
    checkOutput("after_rst_dim_row", int'(busInst.dim_row), 1);
    checkOutput("after_rst_dim_col", int'(busInst.dim_col), 1);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/matrix_input_parser.md
# matrix_input_parser

Receive-side counterpart of the matrix info display path. It consumes the byte stream from the UART receiver, parses ASCII decimal tokens "rows cols e0 e1 …", and range-checks each token. It emits row-major element writes plus one commit pulse toward the multi-matrix storage. It owns no storage; the storage latches dimensions on `commit`.

## Interface
- `MAX_SIZE`, 5, maximum rows/cols accepted (valid 1..MAX_SIZE)
- `DATA_WIDTH`, 8, width of an element value
- `VAL_MAX`, 9, largest legal element value
- `clk` in 1: system clock
- `rst_n` in 1: asynchronous, active-low reset
- `start_req` in 1: pulse; arms parser for one matrix
- `busy` out 1: high from accepted `start_req` until `done`
- `rx_valid` in 1: one-cycle strobe, `rx_data` valid
- `rx_data` in 8: received ASCII byte
- `wr_en` out 1: one-cycle element write strobe
- `wr_idx` out 5: row-major element index, 0..rows*cols-1
- `wr_data` out DATA_WIDTH: element value
- `dim_row` out 3: parsed rows, held until next start
- `dim_col` out 3: parsed cols, held until next start
- `commit` out 1: one-cycle pulse; matrix complete, all elements written
- `done` out 1: one-cycle pulse at end of every session, success or error
- `err_code` out 2: valid with `done`
  - 0: ok
  - 1: illegal character
  - 2: dimension out of range
  - 3: value > VAL_MAX

## Operation
- Reset values:
  - `busy`, `wr_en`, `commit`, `done` = 0
  - `wr_idx`, `wr_data`, `err_code` = 0
  - `dim_row`, `dim_col` = 1
  - state `S_IDLE`
- Byte classes:
  - digit '0'..'9' (0x30..0x39)
  - separator: space 0x20, CR 0x0D, LF 0x0A
  - any other byte is illegal
- Token accumulation:
  - Accumulator is 10 bits: `acc <= acc*10 + digit`.
  - A sticky overflow flag sets if `acc` exceeds 1023 or the limit of the current field.
  - A token closes on a separator only if at least one digit was seen.
  - Repeated separators are ignored.
- States:
  - `S_IDLE`: `busy`=0; `rx_valid` ignored. `start_req` sets `busy`=1, clears acc and index, goes to `S_GET_ROW`.
  - `S_GET_ROW`: on token close, value must be 1..MAX_SIZE. Store to `dim_row`, go to `S_GET_COL`; otherwise go to `S_ERR` with code 2.
  - `S_GET_COL`: same check as `S_GET_ROW`; stores `dim_col`, latches `total = rows*cols`, goes to `S_GET_ELEM`.
  - `S_GET_ELEM`: on token close with value ≤ VAL_MAX, pulse `wr_en` with `wr_idx` = index and `wr_data` = value, then increment index. When index reaches `total`, go to `S_COMMIT`. Value > VAL_MAX goes to `S_ERR` with code 3.
  - `S_FILL` (see Configuration): one zero write per cycle until index = `total`, then go to `S_COMMIT`.
  - `S_COMMIT`: `commit`=1, `done`=1, `err_code`=0 for one cycle, then `S_IDLE`.
  - `S_ERR`: `done`=1 with the latched `err_code` for one cycle, then `S_IDLE`. No `commit`. Writes already issued stand; storage discards them without a commit.
- An illegal byte in any active state goes to `S_ERR` with code 1.
- In `S_GET_ROW`/`S_GET_COL`, CR/LF with no pending digits are ignored (blank lines).
- In `S_GET_ELEM`, CR/LF closes any pending token as usual; if elements are still missing, behaviour follows Configuration.
- Bytes arriving after the last element closes are ignored (state is `S_COMMIT`/`S_IDLE`).
- `start_req` while `busy`=1 is ignored.

## Timing
- `wr_en` asserts the cycle after the `rx_valid` cycle carrying the closing separator.
- `commit`/`done` assert the cycle after the final `wr_en`.
- `busy` falls the cycle after `done`.
- At most one `wr_en` per cycle. Consecutive `rx_valid` strobes (back-to-back, 1 cycle apart) must be handled without loss.
- In `S_FILL`, incoming `rx_valid` bytes are dropped.
- Asynchronous reset mid-session aborts immediately: no `commit`, no `done`, all outputs return to reset values.
- `start_req` coincident with `rx_valid` in `S_IDLE`: the byte is dropped; parsing starts with the next byte.

## Configuration
- `MATRIX_PARSER_ZERO_FILL_EN`
- Defined: CR/LF in `S_GET_ELEM` with index < `total` (after closing any pending token) enters `S_FILL`. Remaining elements are written as 0, one per cycle, then commit.
- Undefined: CR/LF in `S_GET_ELEM` with index < `total` goes to `S_ERR` with code 1.
- CR/LF in `S_GET_ELEM` when index already equals `total` cannot occur, since the commit happens first.

## Test plan
- start, "2 3 1 2 3 4 5 6 " → six `wr_en` with idx 0..5 and data 1..6. Then `commit`=1, `done`=1, `err_code`=0, `dim_row`=2, `dim_col`=3; `busy` low one cycle later.
- start, "6 2 " → `done` with `err_code`=2, no `wr_en`, no `commit`. Also "0 " → code 2.
- start, "1 2 4 12 " → one write (idx0=4), then `done` with `err_code`=3, no `commit`.
- start, "2 2 1 x" → one write, then `done` with `err_code`=1.
- start, "2 2 7\n":
  - with `MATRIX_PARSER_ZERO_FILL_EN`: writes idx0=7, then idx1..3=0 in three consecutive cycles, then `commit`.
  - without: one write, then `done` with `err_code`=1.
- Reset asserted after "3 3 1 " → all outputs at reset values immediately. A subsequent start with "1 1 5 " commits a 1×1 matrix with idx0=5.
